// File: rtl/mems_pkg.sv
// mems_pkg: shared FSM states and DAC frame defaults for the MEMS scan path
package mems_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} state_t;
  localparam int DAC_WIDTH    = 24;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_SYNC_GAP = 2;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period timer; primed high by load, runs while en
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic stop,
  output logic sclk,
  output logic phase_end
);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [HW-1:0] half_cnt;
  logic ph;
  assign phase_end = en && half_cnt == HW'(CLK_DIV - 1);
  // sclk leads with the high phase so data set up in LOAD is stable before the first fall
  always_ff @(posedge clk) begin
    if (rst || !(en || load)) begin
      half_cnt <= '0;
      ph       <= 1'b0;
      sclk     <= 1'b0;
    end else if (load) begin
      half_cnt <= '0;
      ph       <= 1'b0;
      sclk     <= 1'b1;
    end else if (phase_end) begin
      half_cnt <= '0;
      ph       <= !ph;
      sclk     <= ph && !stop;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mems_spi_tx.sv
// mems_spi_tx: fetches a DAC command word from the scan ROM and shifts it out over SPI
module mems_spi_tx
  import mems_pkg::*;
#(
  parameter int DATA_WIDTH  = DAC_WIDTH,
  parameter int ADDR_WIDTH  = 16,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int ROM_LATENCY = 1,
  parameter int SYNC_GAP    = DEF_SYNC_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  sync_n
);
  localparam int BW = $clog2(DATA_WIDTH);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] sr, sr_n;
  logic [ADDR_WIDTH-1:0] rom_addr_n;
  logic mosi_n, sync_n_n, busy_n, phase_end, bit_end, last;
  assign last    = bit_cnt == BW'(DATA_WIDTH - 1);
  assign bit_end = phase_end && !sclk;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk       (clk),
    .rst       (rst),
    .load      (state == LOAD),
    .en        (state == SHIFT),
    .stop      (last),
    .sclk      (sclk),
    .phase_end (phase_end)
  );
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_cnt;
    sr_n       = sr;
    rom_addr_n = rom_addr;
    mosi_n     = mosi;
    sync_n_n   = sync_n;
    busy_n     = busy;
    unique case (state)
      IDLE: if (start) begin
        rom_addr_n = addr;
        busy_n     = 1'b1;
        cnt_n      = '0;
        state_n    = FETCH;
      end
      FETCH: begin
        cnt_n   = cnt == 8'(ROM_LATENCY - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == 8'(ROM_LATENCY - 1) ? LOAD : FETCH;
      end
      LOAD: begin
        sr_n     = rom_data;
        mosi_n   = rom_data[DATA_WIDTH-1];
        sync_n_n = 1'b0;
        bit_n    = '0;
        state_n  = SHIFT;
      end
      SHIFT: if (bit_end) begin
        if (last) begin
          sync_n_n = 1'b1;
          mosi_n   = 1'b0;
          cnt_n    = '0;
          state_n  = GAP;
        end else begin
          sr_n   = sr << 1;
          mosi_n = sr[DATA_WIDTH-2];
          bit_n  = bit_cnt + 1'b1;
        end
      end
      GAP: begin
        cnt_n   = cnt == 8'(SYNC_GAP - 1) ? '0 : cnt + 1'b1;
        busy_n  = cnt != 8'(SYNC_GAP - 1);
        state_n = cnt == 8'(SYNC_GAP - 1) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rom_addr <= '0;
      mosi     <= 1'b0;
      sync_n   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sr       <= sr_n;
      rom_addr <= rom_addr_n;
      mosi     <= mosi_n;
      sync_n   <= sync_n_n;
      busy     <= busy_n;
    end
  end
endmodule
